pixel_framebuffer: RTL and testbench

1-bit-per-pixel frame buffer of 320x200 logical pixels sitting between the game logic (writer) and display_vga (reader).
- Serves display_vga's read request (read, read_h, read_v) with a registered pixel one cycle later, matching display_vga's read1 delay.
- The read coordinates are 640x400 and are scaled down by 2.
- Accepts pixel writes from the game/sprite renderer through a valid/ready handshake.
- Clears itself after reset and on request.

---
 rtl/pixel_framebuffer.sv | 105 ++++++++++
 tb/tb_pixel_framebuffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_framebuffer.sv
// 1-bpp 320x200 frame buffer: 2x-scaled display reads, valid/ready pixel writes,
// and a full self-clear after reset or on request.
module pixel_framebuffer #(
  parameter int unsigned FB_W        = 320,
  parameter int unsigned FB_H        = 200,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned DEPTH       = 64000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       read,
  input  logic [9:0] read_h,
  input  logic [8:0] read_v,
  output logic       pixel,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [8:0] wr_x,
  input  logic [7:0] wr_y,
  input  logic       wr_data,
  input  logic       clear_req,
  output logic       busy
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t      state, state_next;
  logic [15:0] clr_addr, clr_addr_next;
  logic        mem [DEPTH];

  logic [9:0]  rx;
  logic [8:0]  ry;
  logic        rd_in_range, wr_in_range, wr_fire;
  logic        we, wdata;
  logic [15:0] waddr;

  // Row stride of 320 built from shifts: y*256 + y*64 + x.
  function automatic logic [15:0] addr_of(input logic [8:0] x, input logic [7:0] y);
    logic [15:0] y16;
    y16 = {8'd0, y};
    return (y16 << 8) + (y16 << 6) + {7'd0, x};
  endfunction

  assign rx          = read_h >> SCALE_SHIFT;
  assign ry          = read_v >> SCALE_SHIFT;
  assign rd_in_range = (rx < 10'(FB_W)) && (ry < 9'(FB_H));
  assign wr_in_range = (wr_x < 9'(FB_W)) && (wr_y < 8'(FB_H));
  assign wr_fire     = wr_valid && wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    busy          = 1'b0;
    wr_ready      = 1'b0;
    case (state)
      CLEAR: begin
        busy          = 1'b1;
        clr_addr_next = clr_addr + 16'd1;
        if (clr_addr == 16'(DEPTH - 1)) begin
          state_next    = IDLE;
          clr_addr_next = '0;
        end
      end
      IDLE: begin
        wr_ready = 1'b1;
        if (clear_req) state_next = CLEAR;
      end
      default: state_next = CLEAR;
    endcase
  end

  // Single write port shared by the clear sweep and accepted in-range writes;
  // out-of-range writes still handshake but never reach the array.
  always_comb begin
    we    = 1'b0;
    waddr = clr_addr;
    wdata = 1'b0;
    if (state == CLEAR) begin
      we = 1'b1;
    end else if (wr_fire && wr_in_range) begin
      we    = 1'b1;
      waddr = addr_of(wr_x, wr_y);
      wdata = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pixel <= 1'b0;
    else     pixel <= (read && state == IDLE && rd_in_range) ? mem[addr_of(rx[8:0], ry[7:0])] : 1'b0;
  end

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Self-checking bench for pixel_framebuffer against a per-cycle array model;
// frame height is reduced so each clear pass stays short.
module tb_pixel_framebuffer;

  localparam int unsigned FB_W  = 320;
  localparam int unsigned FB_H  = 40;
  localparam int unsigned SS    = 1;
  localparam int unsigned DEPTH = FB_W * FB_H;

  logic       clk = 1'b0;
  logic       rst;
  logic       read;
  logic [9:0] read_h;
  logic [8:0] read_v;
  logic       pixel;
  logic       wr_valid;
  logic       wr_ready;
  logic [8:0] wr_x;
  logic [7:0] wr_y;
  logic       wr_data;
  logic       clear_req;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bit model [DEPTH];
  int clr_left;

  pixel_framebuffer #(
    .FB_W(FB_W), .FB_H(FB_H), .SCALE_SHIFT(SS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .read(read), .read_h(read_h), .read_v(read_v), .pixel(pixel),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .clear_req(clear_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic zero_model();
    foreach (model[i]) model[i] = 1'b0;
  endtask

  // One clock: predict from the model, advance the model, clock the DUT, compare.
  task automatic step();
    int  xa, ya;
    logic exp_pix;
    xa = int'(read_h) >> SS;
    ya = int'(read_v) >> SS;
    exp_pix = 1'b0;
    if (!rst && read && clr_left == 0 && xa < FB_W && ya < FB_H)
      exp_pix = model[ya * FB_W + xa];
    if (rst) begin
      clr_left = DEPTH;
      zero_model();
    end else if (clr_left > 0) begin
      clr_left--;
    end else begin
      if (wr_valid && int'(wr_x) < FB_W && int'(wr_y) < FB_H)
        model[int'(wr_y) * FB_W + int'(wr_x)] = wr_data;
      if (clear_req) begin
        clr_left = DEPTH;
        zero_model();
      end
    end
    @(posedge clk);
    #1;
    chk("pixel", pixel, exp_pix);
    chk("busy", busy, clr_left > 0);
    chk("wr_ready", wr_ready, clr_left == 0);
  endtask

  task automatic rand_read();
    read   = 1'($urandom_range(0, 1));
    read_h = 10'($urandom_range(0, 639));
    read_v = 9'($urandom_range(0, 2 * FB_H + 9));
  endtask

  task automatic set_read(input int x, input int y);
    read   = 1'b1;
    read_h = 10'(2 * x + int'($urandom_range(0, 1)));
    read_v = 9'(2 * y + int'($urandom_range(0, 1)));
  endtask

  task automatic do_write(input int x, input int y, input logic d);
    wr_valid = 1'b1;
    wr_x     = 9'(x);
    wr_y     = 8'(y);
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  int cnt;
  int fx [6];
  int fy [6];

  initial begin
    rst = 1'b1; read = 1'b0; read_h = '0; read_v = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = 1'b0; clear_req = 1'b0;
    clr_left = DEPTH;
    zero_model();

    // Reset held 5 cycles, then the post-reset clear must last exactly DEPTH cycles.
    repeat (5) begin rand_read(); step(); end
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b1);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_pixel", pixel, 1'b0);
    cnt = 0;
    while (busy === 1'b1 && cnt < DEPTH + 100) begin
      rand_read(); read = 1'b1; step(); cnt++;
    end
    chk_int("reset_clear_len", cnt, DEPTH);

    // Basic write then scaled reads.
    read = 1'b0;
    do_write(10, 5, 1'b1);
    read = 1'b1; read_h = 10'd20; read_v = 9'd10; step(); chk("rd_20_10", pixel, 1'b1);
    read_h = 10'd21; read_v = 9'd11; step(); chk("rd_21_11", pixel, 1'b1);
    read_h = 10'd22; read_v = 9'd10; step(); chk("rd_22_10", pixel, 1'b0);
    read = 1'b0; read_h = 10'd20; read_v = 9'd10; step(); chk("rd_off", pixel, 1'b0);

    // Out-of-range writes complete the handshake but must not alias.
    chk("oor_ready", wr_ready, 1'b1);
    do_write(320, 0, 1'b1);
    do_write(0, FB_H, 1'b1);
    do_write(0, 200, 1'b1);
    read = 1'b1; read_h = 10'd0; read_v = 9'd2; step(); chk("oor_alias_0_1", pixel, 1'b0);
    read_v = 9'd0; step(); chk("oor_alias_0_0", pixel, 1'b0);

    // Read-before-write on the same address.
    read = 1'b1; read_h = 10'd14; read_v = 9'd14;
    do_write(7, 7, 1'b1);
    chk("rbw_old", pixel, 1'b0);
    step();
    chk("rbw_new", pixel, 1'b1);

    // Fill pixels, check them, then clear with a redundant mid-clear request.
    for (int i = 0; i < 6; i++) begin
      fx[i] = $urandom_range(0, FB_W - 1);
      fy[i] = $urandom_range(0, FB_H - 1);
      read = 1'b0;
      do_write(fx[i], fy[i], 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      set_read(fx[i], fy[i]); step(); chk("fill_rd", pixel, 1'b1);
    end
    clear_req = 1'b1;
    do_write(1, 1, 1'b1);
    clear_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < DEPTH + 100) begin
      if (cnt == DEPTH / 2) clear_req = 1'b1;
      rand_read(); step(); cnt++;
      clear_req = 1'b0;
    end
    chk_int("clear_len", cnt, DEPTH);
    for (int i = 0; i < 6; i++) begin
      set_read(fx[i], fy[i]); step(); chk("cleared_rd", pixel, 1'b0);
    end
    set_read(1, 1); step(); chk("cleared_same_cycle_wr", pixel, 1'b0);

    // Reset mid-clear restarts the sweep; a pending write waits for the first idle cycle.
    read = 1'b0;
    clear_req = 1'b1; step(); clear_req = 1'b0;
    repeat (DEPTH / 2) begin rand_read(); step(); end
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b1);
    chk("midrst_wr_ready", wr_ready, 1'b0);
    chk("midrst_pixel", pixel, 1'b0);
    step();
    rst = 1'b0;
    wr_valid = 1'b1; wr_x = 9'd3; wr_y = 8'd4; wr_data = 1'b1;
    cnt = 0;
    while (wr_ready === 1'b0 && cnt < DEPTH + 100) begin
      rand_read(); step(); cnt++;
    end
    chk_int("midrst_clear_len", cnt, DEPTH);
    step();
    wr_valid = 1'b0;
    set_read(3, 4); step(); chk("midrst_wr_rd", pixel, 1'b1);

    // Random mixed traffic in idle.
    repeat (400) begin
      rand_read();
      wr_valid = 1'($urandom_range(0, 1));
      wr_x     = 9'($urandom_range(0, 330));
      wr_y     = 8'($urandom_range(0, FB_H + 5));
      wr_data  = 1'($urandom_range(0, 1));
      step();
    end
    wr_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
